// File: rtl/tactile_scan_ctrl.sv
// tactile_scan_ctrl: sequences one tactile-array frame (row drive, read-mux step, settle, ADC, pixel stream).
// Latency: per pixel SETTLE_TICKS scan_ticks + 1 CONVERT cycle + ADC time + 1 OUTPUT cycle (px_ready=1).
// Backpressure: pixel held in OUTPUT until px_ready; no further settle/convert starts meanwhile.
// Option: define SCAN_TIMEOUT_EN to bound each ADC conversion (err_timeout, px_data forced to all ones).
module tactile_scan_ctrl #(
  parameter int ROW_CNT      = 8,
  parameter int RD_WIRE_CNT  = 2,
  parameter int SETTLE_TICKS = 4,
  parameter int DATA_W       = 12,
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic                           clk_ref,
  input  logic                           rst,
  input  logic                           scan_tick,
  input  logic                           start,
  input  logic                           continuous,
  output logic                           busy,
  output logic [ROW_CNT-1:0]             row_sel,
  output logic [$clog2(RD_WIRE_CNT)-1:0] rd_sel,
  output logic                           adc_start,
  input  logic                           adc_valid,
  input  logic [DATA_W-1:0]              adc_data,
  output logic                           px_valid,
  input  logic                           px_ready,
  output logic [DATA_W-1:0]              px_data,
  output logic [$clog2(ROW_CNT)-1:0]     px_row,
  output logic [$clog2(RD_WIRE_CNT)-1:0] px_col,
  output logic                           px_last,
  output logic                           frame_done,
  output logic                           err_timeout
);

  localparam int RW = $clog2(ROW_CNT);
  localparam int CW = $clog2(RD_WIRE_CNT);
  localparam int SW = $clog2(SETTLE_TICKS + 1);

  localparam logic [RW-1:0]      ROW_LAST    = RW'(ROW_CNT - 1);
  localparam logic [CW-1:0]      COL_LAST    = CW'(RD_WIRE_CNT - 1);
  localparam logic [SW-1:0]      SETTLE_LAST = SW'(SETTLE_TICKS - 1);
  localparam logic [ROW_CNT-1:0] ROW_FIRST   = ROW_CNT'(1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CONVERT,
    WAIT_ADC,
    OUTPUT
  } state_t;

  state_t        state;
  logic [RW-1:0] row;         // current drive row index; rd_sel doubles as the column index
  logic [SW-1:0] settle_cnt;  // scan_tick pulses seen since entering SETTLE

`ifdef SCAN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] to_cnt;      // cycles spent in WAIT_ADC for the current conversion
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign err_timeout = 1'b0;
`endif

  // Scan sequencer: every output is a register updated alongside the state transition.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state      <= IDLE;
      row        <= '0;
      settle_cnt <= '0;
      row_sel    <= '0;
      rd_sel     <= '0;
      adc_start  <= 1'b0;
      px_valid   <= 1'b0;
      px_data    <= '0;
      px_row     <= '0;
      px_col     <= '0;
      px_last    <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
`ifdef SCAN_TIMEOUT_EN
      to_cnt      <= '0;
      err_timeout <= 1'b0;
`endif
    end else begin
      adc_start  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= SETTLE;
            busy       <= 1'b1;
            row        <= '0;
            rd_sel     <= '0;
            settle_cnt <= '0;
            row_sel    <= ROW_FIRST;
`ifdef SCAN_TIMEOUT_EN
            err_timeout <= 1'b0;
`endif
          end
        end

        SETTLE: begin
          if (scan_tick) begin
            settle_cnt <= settle_cnt + 1'b1;
            if (settle_cnt == SETTLE_LAST) begin
              state     <= CONVERT;
              adc_start <= 1'b1;
            end
          end
        end

        CONVERT: begin
          state <= WAIT_ADC;
`ifdef SCAN_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end

        WAIT_ADC: begin
`ifdef SCAN_TIMEOUT_EN
          to_cnt <= to_cnt + 1'b1;
          if (adc_valid || to_cnt == TO_LAST) begin
            // A missing conversion still yields a pixel so the frame completes.
            px_data <= adc_valid ? adc_data : {DATA_W{1'b1}};
            if (!adc_valid) err_timeout <= 1'b1;
`else
          if (adc_valid) begin
            px_data <= adc_data;
`endif
            px_row   <= row;
            px_col   <= rd_sel;
            px_last  <= (row == ROW_LAST) && (rd_sel == COL_LAST);
            px_valid <= 1'b1;
            state    <= OUTPUT;
          end
        end

        OUTPUT: begin
          if (px_ready) begin
            px_valid   <= 1'b0;
            settle_cnt <= '0;
            if (px_last) begin
              frame_done <= 1'b1;
              row        <= '0;
              rd_sel     <= '0;
              if (continuous) begin
                state   <= SETTLE;
                row_sel <= ROW_FIRST;
              end else begin
                state   <= IDLE;
                row_sel <= '0;
                busy    <= 1'b0;
              end
            end else if (rd_sel == COL_LAST) begin
              // Column runs fastest; wrapping it advances the drive row.
              rd_sel  <= '0;
              row     <= row + 1'b1;
              row_sel <= row_sel << 1;
              state   <= SETTLE;
            end else begin
              rd_sel <= rd_sel + 1'b1;
              state  <= SETTLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tactile_scan_ctrl.sv
// tb_tactile_scan_ctrl: scoreboard bench for tactile_scan_ctrl (4 rows x 2 read wires, 2 settle ticks).
// The ADC model echoes {row,col} of the driven row/column; expected pixels are queued per frame.
// Pixels are popped and compared whenever px_valid && px_ready is observed.
module tb_tactile_scan_ctrl;

  localparam int ROWS = 4;
  localparam int COLS = 2;
  localparam int ST   = 2;
  localparam int DW   = 12;
  localparam int TO   = 16;

  logic            clk_ref = 1'b0;
  logic            rst;
  logic            scan_tick;
  logic            start;
  logic            continuous;
  logic            busy;
  logic [ROWS-1:0] row_sel;
  logic            rd_sel;
  logic            adc_start;
  logic            adc_valid;
  logic [DW-1:0]   adc_data;
  logic            px_valid;
  logic            px_ready;
  logic [DW-1:0]   px_data;
  logic [1:0]      px_row;
  logic            px_col;
  logic            px_last;
  logic            frame_done;
  logic            err_timeout;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    row;
    logic          col;
    logic          last;
  } px_t;

  px_t sb[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  frames_done = 0;
  int  adc_convs   = 0;
  int  adc_lat     = 1;
  bit  adc_hang    = 1'b0;

  tactile_scan_ctrl #(
    .ROW_CNT(ROWS), .RD_WIRE_CNT(COLS), .SETTLE_TICKS(ST), .DATA_W(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk_ref(clk_ref), .rst(rst), .scan_tick(scan_tick), .start(start), .continuous(continuous),
    .busy(busy), .row_sel(row_sel), .rd_sel(rd_sel), .adc_start(adc_start),
    .adc_valid(adc_valid), .adc_data(adc_data), .px_valid(px_valid), .px_ready(px_ready),
    .px_data(px_data), .px_row(px_row), .px_col(px_col), .px_last(px_last),
    .frame_done(frame_done), .err_timeout(err_timeout)
  );

  always #5 clk_ref = ~clk_ref;

  function automatic logic [1:0] row_idx(input logic [ROWS-1:0] oh);
    row_idx = 2'd0;
    for (int i = 0; i < ROWS; i++) if (oh[i]) row_idx = 2'(i);
  endfunction

  // scan_tick strobe every 4 cycles
  initial begin
    int tc;
    tc = 0;
    scan_tick = 1'b0;
    forever begin
      @(negedge clk_ref);
      tc = (tc + 1) % 4;
      scan_tick = (tc == 0);
    end
  end

  // ADC model: answers each adc_start after adc_lat cycles with {row,col}
  initial begin
    adc_valid = 1'b0;
    adc_data  = '0;
    forever begin
      @(negedge clk_ref);
      adc_valid = 1'b0;
      if (adc_start === 1'b1) begin
        adc_convs++;
        if (!(adc_hang && row_sel == 4'b0001 && rd_sel == 1'b1)) begin
          repeat (adc_lat) @(negedge clk_ref);
          adc_data  = DW'({row_idx(row_sel), rd_sel});
          adc_valid = 1'b1;
        end
      end
    end
  end

  // Output monitor: pops the scoreboard on every accepted pixel
  initial begin
    px_t exp_px, got_px;
    forever begin
      @(negedge clk_ref);
      #1;
      if (frame_done === 1'b1) frames_done++;
      if (px_valid === 1'b1 && px_ready === 1'b1) begin
        got_px = {px_data, px_row, px_col, px_last};
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL pixel_unexpected: got row=%0d col=%0d data=%h last=%b, expected no pixel",
                   px_row, px_col, px_data, px_last);
        end else begin
          exp_px = sb.pop_front();
          if (got_px !== exp_px)  begin
            miscompares++;
            $display("FAIL pixel: got row=%0d col=%0d data=%h last=%b, expected row=%0d col=%0d data=%h last=%b",
                     got_px.row, got_px.col, got_px.data, got_px.last,
                     exp_px.row, exp_px.col, exp_px.data, exp_px.last);
          end
        end
      end
    end
  end

  task automatic push_frame(input bit hang01);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        px_t e;
        e.row  = 2'(r);
        e.col  = 1'(c);
        e.last = (r == ROWS - 1) && (c == COLS - 1);
        e.data = (hang01 && r == 0 && c == 1) ? {DW{1'b1}} : DW'({e.row, e.col});
        sb.push_back(e);
      end
    end
  endtask

  task automatic pulse_start;
    @(negedge clk_ref);
    start = 1'b1;
    @(negedge clk_ref);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk_ref);
      if (busy === 1'b0) done = 1'b1;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL %s_idle: busy still %b after %0d cycles, expected 0", name, busy, budget);
    end
    @(negedge clk_ref);
    #2;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk_ref);
    vectors++;
    if ({row_sel, rd_sel, adc_start, px_valid, px_data, px_row, px_col, px_last,
         frame_done, busy, err_timeout} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: got row_sel=%b rd_sel=%b adc_start=%b px_valid=%b px_data=%h busy=%b err=%b, expected all 0",
               row_sel, rd_sel, adc_start, px_valid, px_data, busy, err_timeout);
    end
    rst = 1'b0;
  endtask

  task automatic test_frame;
    int  f0, c0, ticks;
    bit  seen;
    f0 = frames_done;
    c0 = adc_convs;
    push_frame(1'b0);
    pulse_start();
    vectors++;
    if (row_sel !== 4'b0001 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL start_row_sel: got row_sel=%b busy=%b, expected 0001/1", row_sel, busy);
    end
    ticks = 0;
    seen  = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      #1;
      if (scan_tick === 1'b1) ticks++;
      @(negedge clk_ref);
      if (adc_start === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen || ticks != ST) begin
      miscompares++;
      $display("FAIL settle_ticks: got %0d ticks (adc_start seen=%b), expected %0d", ticks, seen, ST);
    end
    @(negedge clk_ref);
    vectors++;
    if (adc_start !== 1'b0) begin
      miscompares++;
      $display("FAIL adc_start_pulse: got %b one cycle later, expected 0", adc_start);
    end
    wait_idle(2000, "frame");
    vectors++;
    if (frames_done - f0 != 1 || adc_convs - c0 != ROWS * COLS || sb.size() != 0 || row_sel !== '0) begin
      miscompares++;
      $display("FAIL frame_end: got frame_done=%0d convs=%0d left=%0d row_sel=%b, expected 1/8/0/0000",
               frames_done - f0, adc_convs - c0, sb.size(), row_sel);
    end
  endtask

  task automatic test_backpressure;
    int  c0;
    bit  seen;
    push_frame(1'b0);
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      if (px_valid === 1'b1 && px_row == 2'd1 && px_col == 1'b1) seen = 1'b1;
      else @(negedge clk_ref);
    end
    px_ready = 1'b0;
    c0 = adc_convs;
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL bp_reach: pixel (1,1) never valid, expected it within 2000 cycles");
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_ref);
      vectors++;
      if (px_valid !== 1'b1 || px_data !== 12'd3 || px_row !== 2'd1 || px_col !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold cycle %0d: got valid=%b data=%h row=%0d col=%0d, expected 1/003/1/1",
                 i, px_valid, px_data, px_row, px_col);
      end
    end
    vectors++;
    if (adc_convs != c0) begin
      miscompares++;
      $display("FAIL bp_no_adc: got %0d conversions during stall, expected 0", adc_convs - c0);
    end
    px_ready = 1'b1;
    wait_idle(2000, "bp");
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL bp_drain: got %0d pixels outstanding, expected 0", sb.size());
    end
  endtask

  task automatic test_continuous;
    int  f0;
    bit  seen;
    f0 = frames_done;
    continuous = 1'b1;
    push_frame(1'b0);
    push_frame(1'b0);
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk_ref);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen || row_sel !== 4'b0001 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL cont_restart: got done=%b row_sel=%b busy=%b, expected 1/0001/1", seen, row_sel, busy);
    end
    continuous = 1'b0;
    wait_idle(2000, "cont");
    vectors++;
    if (frames_done - f0 != 2 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL cont_frames: got %0d frames, %0d left, expected 2 frames, 0 left",
               frames_done - f0, sb.size());
    end
  endtask

  task automatic test_start_while_busy;
    int  f0, c0;
    bit  seen;
    f0 = frames_done;
    c0 = adc_convs;
    adc_lat = 3;
    push_frame(1'b0);
    pulse_start();
    pulse_start();               // lands in SETTLE
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk_ref);
      if (adc_start === 1'b1) seen = 1'b1;
    end
    start = 1'b1;                // DUT enters WAIT_ADC at the next edge
    @(negedge clk_ref);
    start = 1'b1;
    @(negedge clk_ref);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk_ref);
      if (px_valid === 1'b1 && px_last === 1'b1) seen = 1'b1;
    end
    start = 1'b1;                // coincides with last-pixel accept
    @(negedge clk_ref);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL start_at_end: got busy=%b %0d cycles after frame end, expected 0", busy, i);
      end
      @(negedge clk_ref);
    end
    #2;
    vectors++;
    if (frames_done - f0 != 1 || adc_convs - c0 != ROWS * COLS || sb.size() != 0) begin
      miscompares++;
      $display("FAIL start_busy_frame: got frames=%0d convs=%0d left=%0d, expected 1/8/0",
               frames_done - f0, adc_convs - c0, sb.size());
    end
    adc_lat = 1;
  endtask

  task automatic test_reset_mid;
    int  pv;
    bit  seen;
    adc_lat = 6;
    for (int k = 0; k < 4; k++) begin
      px_t e;
      e.row  = 2'(k / 2);
      e.col  = 1'(k % 2);
      e.last = 1'b0;
      e.data = DW'({e.row, e.col});
      sb.push_back(e);
    end
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk_ref);
      if (adc_start === 1'b1 && row_sel == 4'b0100 && rd_sel == 1'b0) seen = 1'b1;
    end
    @(negedge clk_ref);
    rst = 1'b1;
    @(negedge clk_ref);
    rst = 1'b0;
    vectors++;
    if (!seen || {row_sel, rd_sel, adc_start, px_valid, px_data, px_row, px_col, px_last,
                  frame_done, busy, err_timeout} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got reach=%b row_sel=%b busy=%b px_valid=%b px_data=%h, expected 1/0/0/0/0",
               seen, row_sel, busy, px_valid, px_data);
    end
    pv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_ref);
      if (px_valid === 1'b1 || busy === 1'b1) pv++;
    end
    vectors++;
    if (pv != 0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL late_adc: got %0d active cycles, %0d pixels left, expected 0/0", pv, sb.size());
    end
    adc_lat = 1;
    push_frame(1'b0);
    pulse_start();
    wait_idle(2000, "after_rst");
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL fresh_frame: got %0d pixels left, expected 0", sb.size());
    end
  endtask

`ifdef SCAN_TIMEOUT_EN
  task automatic test_timeout;
    bit seen;
    adc_hang = 1'b1;
    push_frame(1'b1);
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk_ref);
      if (adc_start === 1'b1 && row_sel == 4'b0001 && rd_sel == 1'b1) seen = 1'b1;
    end
    repeat (TO) @(negedge clk_ref);
    vectors++;
    if (!seen || err_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_early: got err=%b reach=%b after %0d cycles, expected 0/1", err_timeout, seen, TO);
    end
    @(negedge clk_ref);
    vectors++;
    if (err_timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_set: got err=%b, expected 1", err_timeout);
    end
    wait_idle(2000, "timeout");
    vectors++;
    if (err_timeout !== 1'b1 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL timeout_sticky: got err=%b left=%0d, expected 1/0", err_timeout, sb.size());
    end
    adc_hang = 1'b0;
    push_frame(1'b0);
    pulse_start();
    vectors++;
    if (err_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_clear: got err=%b after start, expected 0", err_timeout);
    end
    wait_idle(2000, "timeout_clr");
  endtask
`else
  task automatic test_timeout;
    vectors++;
    if (err_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_tied: got err=%b, expected 0", err_timeout);
    end
  endtask
`endif

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    continuous = 1'b0;
    px_ready   = 1'b1;
    test_reset();
    test_frame();
    test_backpressure();
    test_continuous();
    test_start_while_busy();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
